// File: rtl/FPALL_pkg.sv
// Shared formats for the FP32 / dual-FP16 adder datapath.
package FPALL_pkg;

   typedef enum logic {
      FMT_FP32 = 1'b0,
      FMT_FP16 = 1'b1
   } fp_fmt_e;

   localparam int FP32_EXP_W  = 8;
   localparam int FP32_SIG_W  = 24;
   localparam int FP16L_EXP_W = 8;
   localparam int FP16L_SIG_W = 8;
   localparam int SH32_MAX    = 31;
   localparam int SH16_MAX    = 15;

   // Stage-1 register contents of the alignment pipe.
   // In FP16 mode the hi lane occupies the upper field halves.
   typedef struct packed {
      fp_fmt_e     fmt;
      logic [1:0]  sign;
      logic [1:0]  eff_sub;
      logic [15:0] big_exp;
      logic [23:0] big_sig;
      logic [23:0] x;
      logic [7:0]  s;
   } align_s1_t;

endpackage

// File: rtl/barrel_shifter.sv
// Lane-packed right shifter with two guard bits and sticky per lane.
module barrel_shifter
   import FPALL_pkg::*;
(
   input  fp_fmt_e     fmt,
   input  logic [23:0] X,
   input  logic [7:0]  S,
   output logic [25:0] R,
   output logic        Sticky_h,
   output logic        Sticky_l
);

   logic [56:0] w_e32;
   logic [24:0] w_eh;
   logic [24:0] w_el;

   // Extended operands: result bits on top, shifted-out bits below.
   assign w_e32 = {X, 2'b00, 31'b0} >> S[4:0];
   assign w_eh  = {X[23:16], 2'b00, 15'b0} >> S[7:4];
   assign w_el  = {X[7:0], 2'b00, 15'b0} >> S[3:0];

   // Select the single-lane or dual-lane result.
   always_comb begin
      R        = w_e32[56:31];
      Sticky_h = 1'b0;
      Sticky_l = |w_e32[30:0];
      if (fmt == FMT_FP16) begin
         R        = {w_eh[24:15], 6'b0, w_el[24:15]};
         Sticky_h = |w_eh[14:0];
         Sticky_l = |w_el[14:0];
      end
   end

endmodule

// File: rtl/fp_lane_cmp_swap.sv
// One lane of exponent/significand compare and operand swap.
module fp_lane_cmp_swap #(
   parameter int EXP_W = 8,
   parameter int SIG_W = 24
) (
   input  logic [EXP_W-1:0] i_exp_a,
   input  logic [SIG_W-2:0] i_frac_a,
   input  logic [EXP_W-1:0] i_exp_b,
   input  logic [SIG_W-2:0] i_frac_b,
   output logic             o_swap,
   output logic [EXP_W-1:0] o_diff,
   output logic [EXP_W-1:0] o_big_exp,
   output logic [SIG_W-1:0] o_big_sig,
   output logic [SIG_W-1:0] o_small_sig
);

   localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

   logic [EXP_W-1:0] w_eexp_a, w_eexp_b;
   logic [SIG_W-1:0] w_sig_a, w_sig_b;

   // Denormals behave as exponent 1 with no hidden bit.
   assign w_eexp_a = (i_exp_a == '0) ? EXP_ONE : i_exp_a;
   assign w_eexp_b = (i_exp_b == '0) ? EXP_ONE : i_exp_b;
   assign w_sig_a  = {(i_exp_a != '0), i_frac_a};
   assign w_sig_b  = {(i_exp_b != '0), i_frac_b};

   // Strict magnitude compare: equal operands keep a as the big one.
   always_comb begin
      o_swap      = {w_eexp_b, w_sig_b} > {w_eexp_a, w_sig_a};
      o_big_exp   = o_swap ? w_eexp_b : w_eexp_a;
      o_big_sig   = o_swap ? w_sig_b  : w_sig_a;
      o_small_sig = o_swap ? w_sig_a  : w_sig_b;
      o_diff      = o_swap ? (w_eexp_b - w_eexp_a) : (w_eexp_a - w_eexp_b);
   end

endmodule

// File: rtl/fp_add_align_pipe.sv
// Two-stage alignment front-end of the shared FP32 / dual-FP16 adder.
module fp_add_align_pipe
   import FPALL_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  fp_fmt_e     in_fmt,
   input  logic        in_op_sub,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output fp_fmt_e     out_fmt,
   output logic [1:0]  out_sign,
   output logic [1:0]  out_eff_sub,
   output logic [15:0] out_big_exp,
   output logic [23:0] out_big_sig,
   output logic [25:0] out_small_sig,
   output logic        out_sticky_h,
   output logic        out_sticky_l
);

   logic              w_32_swap, w_h_swap, w_l_swap;
   logic [7:0]        w_32_diff, w_h_diff, w_l_diff;
   logic [7:0]        w_32_bexp, w_h_bexp, w_l_bexp;
   logic [23:0]       w_32_bsig, w_32_ssig;
   logic [7:0]        w_h_bsig, w_h_ssig, w_l_bsig, w_l_ssig;
   logic [4:0]        w_s32;
   logic [3:0]        w_sh, w_sl;
   align_s1_t         w_s1_d;
   logic              w_s2_ready;
   logic [25:0]       w_r;
   logic              w_sth, w_stl;

   logic              r_s1_v, r_s2_v;
   align_s1_t         r_s1;

   fp_lane_cmp_swap #(.EXP_W(FP32_EXP_W), .SIG_W(FP32_SIG_W)) u_lane32 (
      .i_exp_a(in_a[30:23]), .i_frac_a(in_a[22:0]),
      .i_exp_b(in_b[30:23]), .i_frac_b(in_b[22:0]),
      .o_swap(w_32_swap), .o_diff(w_32_diff), .o_big_exp(w_32_bexp),
      .o_big_sig(w_32_bsig), .o_small_sig(w_32_ssig));

   fp_lane_cmp_swap #(.EXP_W(FP16L_EXP_W), .SIG_W(FP16L_SIG_W)) u_lane_hi (
      .i_exp_a(in_a[30:23]), .i_frac_a(in_a[22:16]),
      .i_exp_b(in_b[30:23]), .i_frac_b(in_b[22:16]),
      .o_swap(w_h_swap), .o_diff(w_h_diff), .o_big_exp(w_h_bexp),
      .o_big_sig(w_h_bsig), .o_small_sig(w_h_ssig));

   fp_lane_cmp_swap #(.EXP_W(FP16L_EXP_W), .SIG_W(FP16L_SIG_W)) u_lane_lo (
      .i_exp_a(in_a[14:7]), .i_frac_a(in_a[6:0]),
      .i_exp_b(in_b[14:7]), .i_frac_b(in_b[6:0]),
      .o_swap(w_l_swap), .o_diff(w_l_diff), .o_big_exp(w_l_bexp),
      .o_big_sig(w_l_bsig), .o_small_sig(w_l_ssig));

   // Shift amounts saturate: beyond the lane width everything lands in sticky.
   assign w_s32 = (w_32_diff > 8'(SH32_MAX)) ? 5'(SH32_MAX) : w_32_diff[4:0];
   assign w_sh  = (w_h_diff  > 8'(SH16_MAX)) ? 4'(SH16_MAX) : w_h_diff[3:0];
   assign w_sl  = (w_l_diff  > 8'(SH16_MAX)) ? 4'(SH16_MAX) : w_l_diff[3:0];

   // Stage-1 next value: pick the FP32 lane or pack the two FP16 lanes.
   always_comb begin
      w_s1_d.fmt     = in_fmt;
      w_s1_d.sign    = {1'b0, w_32_swap ? (in_b[31] ^ in_op_sub) : in_a[31]};
      w_s1_d.eff_sub = {1'b0, in_a[31] ^ in_b[31] ^ in_op_sub};
      w_s1_d.big_exp = {8'b0, w_32_bexp};
      w_s1_d.big_sig = w_32_bsig;
      w_s1_d.x       = w_32_ssig;
      w_s1_d.s       = {3'b0, w_s32};
      if (in_fmt == FMT_FP16) begin
         w_s1_d.sign    = {w_h_swap ? (in_b[31] ^ in_op_sub) : in_a[31],
                           w_l_swap ? (in_b[15] ^ in_op_sub) : in_a[15]};
         w_s1_d.eff_sub = {in_a[31] ^ in_b[31] ^ in_op_sub,
                           in_a[15] ^ in_b[15] ^ in_op_sub};
         w_s1_d.big_exp = {w_h_bexp, w_l_bexp};
         w_s1_d.big_sig = {w_h_bsig, 8'b0, w_l_bsig};
         w_s1_d.x       = {w_h_ssig, 8'b0, w_l_ssig};
         w_s1_d.s       = {w_sh, w_sl};
      end
   end

   assign w_s2_ready = !r_s2_v || out_ready;
   assign in_ready   = !r_s1_v || w_s2_ready;
   assign out_valid  = r_s2_v;

   barrel_shifter u_bsh (
      .fmt(r_s1.fmt), .X(r_s1.x), .S(r_s1.s),
      .R(w_r), .Sticky_h(w_sth), .Sticky_l(w_stl));

   // Stage 1: accept operands; flush drops any same-cycle input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v <= 1'b0;
         r_s1   <= '0;
      end else begin
         if (flush)
            r_s1_v <= 1'b0;
         else if (in_ready)
            r_s1_v <= in_valid;
         if (in_ready && in_valid && !flush)
            r_s1 <= w_s1_d;
      end
   end

   // Stage 2: capture shifter result; data holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v        <= 1'b0;
         out_fmt       <= FMT_FP32;
         out_sign      <= '0;
         out_eff_sub   <= '0;
         out_big_exp   <= '0;
         out_big_sig   <= '0;
         out_small_sig <= '0;
         out_sticky_h  <= 1'b0;
         out_sticky_l  <= 1'b0;
      end else begin
         if (flush)
            r_s2_v <= 1'b0;
         else if (w_s2_ready)
            r_s2_v <= r_s1_v;
         if (w_s2_ready && r_s1_v && !flush) begin
            out_fmt       <= r_s1.fmt;
            out_sign      <= r_s1.sign;
            out_eff_sub   <= r_s1.eff_sub;
            out_big_exp   <= r_s1.big_exp;
            out_big_sig   <= r_s1.big_sig;
            out_small_sig <= w_r;
            out_sticky_h  <= w_sth;
            out_sticky_l  <= w_stl;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_align_pipe.sv
// Scoreboard bench for the alignment pipe with directed vectors.
module tb_fp_add_align_pipe;
   import FPALL_pkg::*;

   typedef struct packed {
      logic        fmt;
      logic [1:0]  sign;
      logic [1:0]  eff;
      logic [15:0] bexp;
      logic [23:0] bsig;
      logic [25:0] ssig;
      logic        sth;
      logic        stl;
   } exp_t;

   typedef struct packed {
      logic        fmt;
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, in_op_sub;
   fp_fmt_e     in_fmt, out_fmt;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [1:0]  out_sign, out_eff_sub;
   logic [15:0] out_big_exp;
   logic [23:0] out_big_sig;
   logic [25:0] out_small_sig;
   logic        out_sticky_h, out_sticky_l;

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t vec[8];
   exp_t snap;

   fp_add_align_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_op_sub(in_op_sub), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt),
      .out_sign(out_sign), .out_eff_sub(out_eff_sub), .out_big_exp(out_big_exp),
      .out_big_sig(out_big_sig), .out_small_sig(out_small_sig),
      .out_sticky_h(out_sticky_h), .out_sticky_l(out_sticky_l));

   always #5 clk = ~clk;

   function automatic exp_t act();
      return {logic'(out_fmt), out_sign, out_eff_sub, out_big_exp, out_big_sig,
              out_small_sig, out_sticky_h, out_sticky_l};
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Monitor: a transfer is seen at the negedge before the edge that completes it.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got=%0h want=none", act());
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (act() !== e) begin
               failures++;
               $display("FAIL output got=%0h want=%0h", act(), e);
            end
         end
      end
   end

   task automatic send(input int idx, input bit push);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      in_fmt    = fp_fmt_e'(vec[idx].fmt);
      in_op_sub = vec[idx].op;
      in_a      = vec[idx].a;
      in_b      = vec[idx].b;
      in_valid  = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) sb.push_back(vec[idx].e);
            done = 1;
         end
         @(posedge clk); #1;
         if (!done) begin
            n++;
            if (n > 50) begin
               checks++;
               failures++;
               $display("FAIL send_timeout got=stalled want=accept");
               done = 1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 128'(sb.size()), 128'd0);
   endtask

   task automatic latency(input int idx);
      in_fmt    = fp_fmt_e'(vec[idx].fmt);
      in_op_sub = vec[idx].op;
      in_a      = vec[idx].a;
      in_b      = vec[idx].b;
      in_valid  = 1'b1;
      @(negedge clk);
      chk("lat_in_ready", 128'(in_ready), 128'd1);
      sb.push_back(vec[idx].e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_cycle1", 128'(out_valid), 128'd0);
      @(posedge clk); #1;
      chk("lat_cycle2", 128'(out_valid), 128'd1);
   endtask

   initial begin
      vec[0] = '{1'b0, 1'b0, 32'h3F800000, 32'h3F000000, '{1'b0, 2'b00, 2'b00, 16'h007F, 24'h800000, 26'h1000000, 1'b0, 1'b0}};
      vec[1] = '{1'b0, 1'b1, 32'h3F000000, 32'h3F800000, '{1'b0, 2'b01, 2'b01, 16'h007F, 24'h800000, 26'h1000000, 1'b0, 1'b0}};
      vec[2] = '{1'b0, 1'b0, 32'h4B800000, 32'h3F800001, '{1'b0, 2'b00, 2'b00, 16'h0097, 24'h800000, 26'h0000002, 1'b0, 1'b1}};
      vec[3] = '{1'b0, 1'b0, 32'h53800000, 32'h3F800000, '{1'b0, 2'b00, 2'b00, 16'h00A7, 24'h800000, 26'h0000000, 1'b0, 1'b1}};
      vec[4] = '{1'b1, 1'b0, 32'h40004000, 32'h3F803800, '{1'b1, 2'b00, 2'b00, 16'h8080, 24'h800080, 26'h1000000, 1'b0, 1'b1}};
      vec[5] = '{1'b1, 1'b1, 32'h3F803F80, 32'h3F804000, '{1'b1, 2'b01, 2'b11, 16'h7F80, 24'h800080, 26'h2000100, 1'b0, 1'b0}};
      vec[6] = '{1'b0, 1'b0, 32'hBF800000, 32'h3F800000, '{1'b0, 2'b01, 2'b01, 16'h007F, 24'h800000, 26'h2000000, 1'b0, 1'b0}};
      vec[7] = '{1'b0, 1'b0, 32'h3F800000, 32'h3FC00000, '{1'b0, 2'b00, 2'b00, 16'h007F, 24'hC00000, 26'h2000000, 1'b0, 1'b0}};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_fmt = FMT_FP32; in_op_sub = 1'b0; in_a = '0; in_b = '0;
      #12;
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_outputs", 128'(act()), 128'd0);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency and basic function, then a full-rate stream.
      latency(0);
      for (int i = 1; i < 8; i++) send(i, 1'b1);
      drain();

      // Backpressure: two fill the pipe, the third waits.
      out_ready = 1'b0;
      send(0, 1'b1);
      send(1, 1'b1);
      in_fmt = FMT_FP32; in_op_sub = vec[2].op; in_a = vec[2].a; in_b = vec[2].b;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_low", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      snap = act();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_stable", 128'(act()), 128'(snap));
         chk("bp_still_blocked", 128'(in_ready), 128'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(2, 1'b1);
      drain();

      // Flush with both stages full and an input offered.
      out_ready = 1'b0;
      send(0, 1'b0);
      send(1, 1'b0);
      in_fmt = FMT_FP32; in_op_sub = vec[3].op; in_a = vec[3].a; in_b = vec[3].b;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_full_out_valid", 128'(out_valid), 128'd0);
      // Flush on an empty pipe with in_ready high: the input must still be dropped.
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("flush_dropped", 128'(out_valid), 128'd0);
      end

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      send(4, 1'b0);
      send(5, 1'b0);
      chk("pre_reset_valid", 128'(out_valid), 128'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 128'(out_valid), 128'd0);
      chk("async_reset_outputs", 128'(act()), 128'd0);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      latency(7);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
